map_bus_wr_capture: RTL
=======================

// Module: map_bus_wr_capture
// PURPOSE
//  Front-end stage that sits directly upstream of the mapper register files.
//  It samples the asynchronous cartridge CPU bus on the fast system clock and
//  detects M2 falling edges. Each CPU write is captured as an {addr, data, rom}
//  record and buffered in a small FIFO. Records are handed to the mapper stage
//  over a valid/ready handshake. A one-cycle m2_fall strobe is also provided
//  for CPU-cycle IRQ counters.
// PARAMETERS
//  SYNC_STG  2  synchronizer flops on m2/cpu_rw/cpu_ce/cpu_addr/cpu_dat (>=2)
//  DEPTH     4  FIFO entries; power of 2, >=2
//  FILT_LEN  3  clocks a new M2 level must hold before acceptance (filter only)
// PORTS
//  clk        in   1   system clock
//  map_rst    in   1   reset, synchronous, active-high
//  m2         in   1   CPU M2 phase, asynchronous
//  cpu_rw     in   1   1=read 0=write, asynchronous
//  cpu_ce     in   1   active-low ROM-space select ($8000-$FFFF)
//  cpu_addr   in   16  CPU address
//  cpu_dat    in   8   CPU data
//  m2_fall    out  1   one-clk pulse per accepted M2 falling edge
//  wr_valid   out  1   head record valid
//  wr_ready   in   1   consumer accepts head when wr_valid&wr_ready
//  wr_addr    out  16  head record address
//  wr_dat     out  8   head record data
//  wr_rom     out  1   head record was ROM-space write (cpu_ce was 0)
//  wr_ovf     out  1   sticky: a write was dropped on full FIFO
//  wr_level   out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  - Clock and reset: one clock (clk); map_rst is synchronous and active-high.
//  - Reset values: m2_fall=0, wr_valid=0, wr_addr=0, wr_dat=0, wr_rom=0,
//    wr_ovf=0, wr_level=0. All sync flops clear to 0. The FIFO is emptied.
//  - Reset mid-operation: pending records are discarded. A capture in flight
//    is lost. No m2_fall is emitted during the reset cycle.
//  - Sync: every bus input passes through SYNC_STG flops. The address, data,
//    rw and ce paths get one extra flop, so they are sampled one clk older
//    than the M2 edge. This keeps data stable at M2 fall.
//  - Edge detect: a registered m2_q holds the accepted M2 level.
//    - A fall is m2_q=1 -> 0.
//    - An "armed" flag is set on the first accepted rising edge after reset.
//      No fall is reported until armed, so a CPU stalled at reset cannot
//      produce a spurious write.
//  - Latency: pin M2 fall to m2_fall = SYNC_STG+1 clks (+FILT_LEN with filter).
//    The push happens in the same clk as m2_fall. wr_valid rises the next clk.
//  - Capture: on m2_fall with delayed cpu_rw=0, push
//    {cpu_addr, cpu_dat, !cpu_ce}. Reads are never pushed.
//  - FIFO: ptrs are log2(DEPTH) bits, wrapping modulo DEPTH. wr_level counts
//    0..DEPTH. Head outputs are registered, first-word fall-through.
//  - Empty: wr_valid=0. Head fields hold their last value. wr_ready ignored.
//  - Full with push and no pop: the record is dropped and wr_ovf is set. It
//    stays set until map_rst.
//  - Full with push and pop in the same clk: both happen, no drop,
//    level unchanged.
//  - Empty with push and ready=1: no pop (valid=0). Level becomes 1.
//  - The producer side never back-pressures. M2 writes at 1.79 MHz must fit
//    well below the clk rate, which is the integrator's responsibility.
// CONFIGURATION
//  MAP_M2_FILT_EN defined:
//    - A FILT_LEN counter sits on synced M2. A level differing from m2_q must
//      persist FILT_LEN consecutive clks before m2_q updates.
//    - Any bounce back resets the counter to 0.
//    - Pulses shorter than FILT_LEN clks are ignored.
//  MAP_M2_FILT_EN undefined:
//    - m2_q follows synced M2 every clk.
//    - FILT_LEN is unused and the counter is absent.
// TESTING
//  1 Reset with m2=0, toggle m2 1->0 once
//    -> one m2_fall, after the first rise only. wr_valid=0 (rw=1).
//  2 Write cpu_addr=16'h800C, dat=8'h01, ce=0, rw=0, M2 fall, ready=0
//    -> wr_valid=1, wr_addr=800C, wr_dat=01, wr_rom=1, wr_level=1.
//  3 Push DEPTH+1 writes with ready=0
//    -> level=DEPTH, wr_ovf=1, last record lost. Drain order matches push order.
//  4 With FIFO full, ready=1 in the same clk as a new push
//    -> no drop, wr_ovf stays 0, level stays DEPTH.
//  5 Assert map_rst with 3 records queued and M2 mid-cycle
//    -> next clk: wr_valid=0, level=0, ovf=0, no m2_fall until re-armed.
//  6 MAP_M2_FILT_EN, FILT_LEN=3: 2-clk M2 low glitch -> no m2_fall.
//    4-clk low -> one m2_fall, latency SYNC_STG+1+3.

Source files
------------

// File: rtl/map_bus_wr_capture.sv
// CPU bus synchronizer, M2-fall write capture and record FIFO for the mapper.
// Define MAP_M2_FILT_EN to add a FILT_LEN-clock glitch filter on synced M2.
module map_bus_wr_capture #(
    parameter int SYNC_STG = 2,
    parameter int DEPTH    = 4,
    parameter int FILT_LEN = 3
) (
    input  logic                    clk,
    input  logic                    map_rst,
    input  logic                    m2,
    input  logic                    cpu_rw,
    input  logic                    cpu_ce,
    input  logic [15:0]             cpu_addr,
    input  logic [7:0]              cpu_dat,
    output logic                    m2_fall,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [15:0]             wr_addr,
    output logic [7:0]              wr_dat,
    output logic                    wr_rom,
    output logic                    wr_ovf,
    output logic [$clog2(DEPTH):0]  wr_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = 26;
    localparam int RW = 25;

    if (SYNC_STG < 2) begin : g_bad_sync
        $error("SYNC_STG must be at least 2");
    end
    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("DEPTH must be a power of two, at least 2");
    end
    if (FILT_LEN < 1) begin : g_bad_filt
        $error("FILT_LEN must be at least 1");
    end

    logic [SYNC_STG-1:0] r_m2_sync;
    logic [BW-1:0]       r_bus_sync [SYNC_STG+1];
    logic                w_m2_s;
    logic [BW-1:0]       w_bus_d;

    assign w_m2_s  = r_m2_sync[SYNC_STG-1];
    assign w_bus_d = r_bus_sync[SYNC_STG];

    // Bus path is one flop longer so fields are sampled before the M2 edge.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            r_m2_sync <= '0;
            for (int i = 0; i <= SYNC_STG; i++) r_bus_sync[i] <= '0;
        end else begin
            r_m2_sync     <= {r_m2_sync[SYNC_STG-2:0], m2};
            r_bus_sync[0] <= {cpu_rw, cpu_ce, cpu_addr, cpu_dat};
            for (int i = 1; i <= SYNC_STG; i++) r_bus_sync[i] <= r_bus_sync[i-1];
        end
    end

    logic r_m2_q;
    logic w_m2_next;

`ifdef MAP_M2_FILT_EN
    localparam int CW = $clog2(FILT_LEN + 1);
    logic [CW-1:0] r_filt_cnt;
    logic [CW-1:0] w_filt_cnt_n;

    always_comb begin
        w_m2_next    = r_m2_q;
        w_filt_cnt_n = '0;
        if (w_m2_s != r_m2_q) begin
            if (r_filt_cnt == CW'(FILT_LEN)) w_m2_next = w_m2_s;
            else w_filt_cnt_n = r_filt_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (map_rst) r_filt_cnt <= '0;
        else         r_filt_cnt <= w_filt_cnt_n;
    end
`else
    assign w_m2_next = w_m2_s;
`endif

    logic          r_armed;
    logic          r_m2_fall;
    logic          r_cap_rw;
    logic [RW-1:0] r_cap_rec;
    logic          w_fall;
    logic          w_push;

    assign w_fall = r_armed & r_m2_q & ~w_m2_next;
    assign w_push = r_m2_fall & ~r_cap_rw;

    always_ff @(posedge clk) begin
        if (map_rst) begin
            r_m2_q    <= 1'b0;
            r_armed   <= 1'b0;
            r_m2_fall <= 1'b0;
            r_cap_rw  <= 1'b1;
            r_cap_rec <= '0;
        end else begin
            r_m2_q    <= w_m2_next;
            r_m2_fall <= w_fall;
            if (~r_m2_q & w_m2_next) r_armed <= 1'b1;
            if (w_fall) begin
                r_cap_rw  <= w_bus_d[25];
                r_cap_rec <= {w_bus_d[23:0], ~w_bus_d[24]};
            end
        end
    end

    logic [RW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_wptr;
    logic [LW-1:0] r_level;
    logic          r_valid;
    logic          r_ovf;
    logic [RW-1:0] r_head;

    logic          w_pop;
    logic          w_full;
    logic          w_push_ok;
    logic          w_drop;
    logic [LW-1:0] w_rest;
    logic [LW-1:0] w_level_n;
    logic [AW-1:0] w_rptr_n;

    always_comb begin
        w_pop     = r_valid & wr_ready;
        w_full    = (r_level == LW'(DEPTH));
        w_push_ok = w_push & (~w_full | w_pop);
        w_drop    = w_push & w_full & ~w_pop;
        w_rest    = r_level - LW'(w_pop);
        w_level_n = w_rest + LW'(w_push_ok);
        w_rptr_n  = r_rptr + AW'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (w_push_ok & ~map_rst) r_mem[r_wptr] <= r_cap_rec;
    end

    // Head register: next stored entry, or the incoming record if none remain.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_level <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_head  <= '0;
        end else begin
            r_rptr  <= w_rptr_n;
            r_wptr  <= r_wptr + AW'(w_push_ok);
            r_level <= w_level_n;
            r_valid <= (w_level_n != '0);
            if (w_drop) r_ovf <= 1'b1;
            if (w_rest != '0)   r_head <= r_mem[w_rptr_n];
            else if (w_push_ok) r_head <= r_cap_rec;
        end
    end

    assign m2_fall  = r_m2_fall;
    assign wr_valid = r_valid;
    assign wr_addr  = r_head[24:9];
    assign wr_dat   = r_head[8:1];
    assign wr_rom   = r_head[0];
    assign wr_ovf   = r_ovf;
    assign wr_level = r_level;

endmodule
